// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StDrain,
        StUpdate,
        StRedirect
    } trap_state_t;

    typedef enum logic [2:0] {
        KindNone,
        KindIllegal,
        KindEbreak,
        KindEcall,
        KindMret,
        KindIrq
    } trap_kind_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
    localparam logic [31:0] CAUSE_EXT_IRQ    = 32'h8000_000B;

    // Fixed priority: ILLEGAL > EBREAK > ECALL > MRET > IRQ.
    function automatic trap_kind_t pick_kind(input logic ill, input logic ebrk,
                                             input logic ecall, input logic mret,
                                             input logic irq);
        if (ill)        return KindIllegal;
        else if (ebrk)  return KindEbreak;
        else if (ecall) return KindEcall;
        else if (mret)  return KindMret;
        else if (irq)   return KindIrq;
        else            return KindNone;
    endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Core-side request/CSR bus of the trap sequencer.
// TRAP_EXT_IRQ_EN adds the level-sensitive EXT_IRQ_i request.
interface trap_sequencer_if;

    logic        EN;
    logic        ILLEGAL_INSTR_i;
    logic        ECALL_i;
    logic        EBREAK_i;
    logic        MRET_i;
    logic [31:0] TRAP_PC_i;
    logic [31:0] TRAP_INSTR_i;
    logic        PIPE_IDLE_i;
    logic        CSR_WE_i;
    logic [11:0] CSR_ADDR_i;
    logic [31:0] CSR_WDATA_i;
`ifdef TRAP_EXT_IRQ_EN
    logic        EXT_IRQ_i;
`endif
    logic        STALL_o;
    logic        FLUSH_o;
    logic        PC_REDIRECT_o;
    logic [31:0] PC_TARGET_o;
    logic [31:0] MTVEC_o;
    logic [31:0] MEPC_o;
    logic [31:0] MCAUSE_o;
    logic [31:0] MTVAL_o;
    logic        MIE_o;
    logic        BUSY_o;

    // Core side: drives requests, observes control and CSR values.
    modport master (
`ifdef TRAP_EXT_IRQ_EN
        output EXT_IRQ_i,
`endif
        output EN, ILLEGAL_INSTR_i, ECALL_i, EBREAK_i, MRET_i, TRAP_PC_i, TRAP_INSTR_i,
        output PIPE_IDLE_i, CSR_WE_i, CSR_ADDR_i, CSR_WDATA_i,
        input  STALL_o, FLUSH_o, PC_REDIRECT_o, PC_TARGET_o,
        input  MTVEC_o, MEPC_o, MCAUSE_o, MTVAL_o, MIE_o, BUSY_o
    );

    // Sequencer side.
    modport slave (
`ifdef TRAP_EXT_IRQ_EN
        input  EXT_IRQ_i,
`endif
        input  EN, ILLEGAL_INSTR_i, ECALL_i, EBREAK_i, MRET_i, TRAP_PC_i, TRAP_INSTR_i,
        input  PIPE_IDLE_i, CSR_WE_i, CSR_ADDR_i, CSR_WDATA_i,
        output STALL_o, FLUSH_o, PC_REDIRECT_o, PC_TARGET_o,
        output MTVEC_o, MEPC_o, MCAUSE_o, MTVAL_o, MIE_o, BUSY_o
    );

endinterface

// File: rtl/trap_sequencer_csr_regs.sv
// Trap CSR storage (mtvec, mepc, mcause, mtval, mstatus.MIE/MPIE).
// Hardware trap updates override a software write to the same CSR in the same cycle.
module trap_csr_regs
    import trap_sequencer_pkg::*;
#(
    parameter logic [31:0] ResetMtvec = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        hw_exc_i,
    input  logic        hw_mret_i,
    input  logic [31:0] hw_mepc_i,
    input  logic [31:0] hw_mcause_i,
    input  logic [31:0] hw_mtval_i,
    input  logic        sw_we_i,
    input  logic [11:0] sw_addr_i,
    input  logic [31:0] sw_wdata_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mcause_o,
    output logic [31:0] mtval_o,
    output logic        mie_o
);

    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;

    // Software write first, then hardware update overrides it.
    always_comb begin
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mtval_d  = mtval_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        if (sw_we_i) begin
            unique case (sw_addr_i)
                CSR_MTVEC:   mtvec_d  = {sw_wdata_i[31:2], 2'b00};
                CSR_MEPC:    mepc_d   = {sw_wdata_i[31:2], 2'b00};
                CSR_MCAUSE:  mcause_d = sw_wdata_i;
                CSR_MTVAL:   mtval_d  = sw_wdata_i;
                CSR_MSTATUS: begin
                    mie_d  = sw_wdata_i[3];
                    mpie_d = sw_wdata_i[7];
                end
                default: ;
            endcase
        end
        if (hw_exc_i) begin
            mepc_d   = hw_mepc_i;
            mcause_d = hw_mcause_i;
            mtval_d  = hw_mtval_i;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (hw_mret_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    // CSR registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtvec_q  <= ResetMtvec;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
        end else begin
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mtval_q  <= mtval_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
        end
    end

    assign mtvec_o  = mtvec_q;
    assign mepc_o   = mepc_q;
    assign mcause_o = mcause_q;
    assign mtval_o  = mtval_q;
    assign mie_o    = mie_q;

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: IDLE -> FLUSH -> DRAIN -> UPDATE -> REDIRECT -> IDLE.
// TRAP_EXT_IRQ_EN enables a lowest-priority external interrupt gated by mstatus.MIE.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC   = 32'h0000_0100,
    parameter int unsigned DRAIN_TIMEOUT = 8
) (
    input logic             CLK,
    input logic             RSTn,
    trap_sequencer_if.slave bus
);

    localparam int unsigned CntW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    trap_state_t state_q, state_d;
    trap_kind_t  kind_q, kind_d;
    trap_kind_t  req_kind;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [31:0] mtvec, mepc, mcause, mtval;
    logic        mie;
    logic        irq_req;
    logic        hw_exc, hw_mret;
    logic [31:0] hw_mcause, hw_mtval;

`ifdef TRAP_EXT_IRQ_EN
    assign irq_req = bus.EXT_IRQ_i & mie;
`else
    assign irq_req = 1'b0;
`endif

    assign req_kind = pick_kind(bus.ILLEGAL_INSTR_i, bus.EBREAK_i, bus.ECALL_i, bus.MRET_i,
                                irq_req);

    // Next-state logic; counter holds DRAIN_TIMEOUT-1 so DRAIN lasts at most DRAIN_TIMEOUT cycles.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.EN && (req_kind != KindNone)) begin
                    kind_d  = req_kind;
                    pc_d    = bus.TRAP_PC_i;
                    instr_d = bus.TRAP_INSTR_i;
                    state_d = StFlush;
                end
            end
            StFlush: begin
                cnt_d   = CntW'(DRAIN_TIMEOUT - 1);
                state_d = StDrain;
            end
            StDrain: begin
                if (bus.PIPE_IDLE_i || (cnt_q == '0)) begin
                    state_d = StUpdate;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StUpdate:   state_d = StRedirect;
            StRedirect: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // FSM and latched event registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= StIdle;
            kind_q  <= KindNone;
            pc_q    <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hardware CSR update values for the latched event.
    always_comb begin
        hw_exc    = (state_q == StUpdate) && (kind_q != KindMret) && (kind_q != KindNone);
        hw_mret   = (state_q == StUpdate) && (kind_q == KindMret);
        hw_mcause = '0;
        hw_mtval  = '0;
        unique case (kind_q)
            KindIllegal: begin
                hw_mcause = CAUSE_ILLEGAL;
                hw_mtval  = instr_q;
            end
            KindEbreak: begin
                hw_mcause = CAUSE_BREAKPOINT;
                hw_mtval  = pc_q;
            end
            KindEcall:  hw_mcause = CAUSE_ECALL_M;
            KindIrq:    hw_mcause = CAUSE_EXT_IRQ;
            default: ;
        endcase
    end

    trap_csr_regs #(
        .ResetMtvec (RESET_MTVEC)
    ) u_csr_regs (
        .clk_i       (CLK),
        .rst_ni      (RSTn),
        .hw_exc_i    (hw_exc),
        .hw_mret_i   (hw_mret),
        .hw_mepc_i   ({pc_q[31:2], 2'b00}),
        .hw_mcause_i (hw_mcause),
        .hw_mtval_i  (hw_mtval),
        .sw_we_i     (bus.CSR_WE_i),
        .sw_addr_i   (bus.CSR_ADDR_i),
        .sw_wdata_i  (bus.CSR_WDATA_i),
        .mtvec_o     (mtvec),
        .mepc_o      (mepc),
        .mcause_o    (mcause),
        .mtval_o     (mtval),
        .mie_o       (mie)
    );

    // Outputs decoded from registered state only.
    always_comb begin
        bus.BUSY_o        = (state_q != StIdle);
        bus.STALL_o       = (state_q != StIdle);
        bus.FLUSH_o       = (state_q == StFlush);
        bus.PC_REDIRECT_o = (state_q == StRedirect);
        bus.PC_TARGET_o   = '0;
        if (state_q == StRedirect) begin
            bus.PC_TARGET_o = (kind_q == KindMret) ? mepc : mtvec;
        end
        bus.MTVEC_o  = mtvec;
        bus.MEPC_o   = mepc;
        bus.MCAUSE_o = mcause;
        bus.MTVAL_o  = mtval;
        bus.MIE_o    = mie;
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: transaction-timeline model plus directed pins.
module tb_trap_sequencer;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    trap_sequencer_if bus ();

    trap_sequencer #(
        .RESET_MTVEC   (32'h0000_0100),
        .DRAIN_TIMEOUT (8)
    ) dut (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: CSR values and the age of the current event (1 = flush cycle).
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;
    logic        m_mie, m_mpie;
    bit          m_active;
    int          m_age, m_drain_end, m_kind;
    logic [31:0] m_pc, m_instr;

    int          dut_redirects = 0;
    logic [31:0] last_target = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mtvec = 32'h100; m_mepc = '0; m_mcause = '0; m_mtval = '0;
        m_mie = 1'b0; m_mpie = 1'b0;
        m_active = 0; m_age = 0; m_drain_end = -1; m_kind = 0;
        m_pc = '0; m_instr = '0;
    endtask

    // Applies one clock edge worth of behaviour using the inputs held across it.
    task automatic model_update();
        bit upd, hw_touch_all;
        if (!rstn) begin
            model_reset();
            return;
        end
        upd = m_active && (m_drain_end >= 0) && (m_age == m_drain_end + 1);
        hw_touch_all = upd && (m_kind != 4);
        if (bus.CSR_WE_i) begin
            case (bus.CSR_ADDR_i)
                12'h305: m_mtvec = bus.CSR_WDATA_i & ~32'h3;
                12'h341: if (!hw_touch_all) m_mepc = bus.CSR_WDATA_i & ~32'h3;
                12'h342: if (!hw_touch_all) m_mcause = bus.CSR_WDATA_i;
                12'h343: if (!hw_touch_all) m_mtval = bus.CSR_WDATA_i;
                12'h300: if (!upd) begin
                    m_mie  = bus.CSR_WDATA_i[3];
                    m_mpie = bus.CSR_WDATA_i[7];
                end
                default: ;
            endcase
        end
        if (!m_active) begin
            int k;
            k = 0;
            if (bus.ILLEGAL_INSTR_i)  k = 1;
            else if (bus.EBREAK_i)    k = 2;
            else if (bus.ECALL_i)     k = 3;
            else if (bus.MRET_i)      k = 4;
`ifdef TRAP_EXT_IRQ_EN
            else if (bus.EXT_IRQ_i && m_mie) k = 5;
`endif
            if (bus.EN && k != 0) begin
                m_active = 1; m_age = 1; m_drain_end = -1; m_kind = k;
                m_pc = bus.TRAP_PC_i; m_instr = bus.TRAP_INSTR_i;
            end
            return;
        end
        if (m_drain_end < 0 && m_age >= 2) begin
            if (bus.PIPE_IDLE_i || (m_age - 1 == 8)) m_drain_end = m_age;
        end else if (upd) begin
            if (m_kind == 4) begin
                m_mie = m_mpie; m_mpie = 1'b1;
            end else begin
                m_mepc = m_pc & ~32'h3;
                case (m_kind)
                    1: begin m_mcause = 32'd2;  m_mtval = m_instr; end
                    2: begin m_mcause = 32'd3;  m_mtval = m_pc;    end
                    3: begin m_mcause = 32'd11; m_mtval = '0;      end
                    default: begin m_mcause = 32'h8000_000B; m_mtval = '0; end
                endcase
                m_mpie = m_mie; m_mie = 1'b0;
            end
        end
        if (m_drain_end >= 0 && m_age == m_drain_end + 2) m_active = 0;
        else m_age++;
    endtask

    task automatic check_all();
        bit e_flush, e_redir;
        logic [31:0] e_target;
        e_flush  = m_active && (m_age == 1);
        e_redir  = m_active && (m_drain_end >= 0) && (m_age == m_drain_end + 2);
        e_target = e_redir ? ((m_kind == 4) ? m_mepc : m_mtvec) : 32'h0;
        chk("busy",     {31'b0, bus.BUSY_o},        {31'b0, m_active});
        chk("stall",    {31'b0, bus.STALL_o},       {31'b0, m_active});
        chk("flush",    {31'b0, bus.FLUSH_o},       {31'b0, e_flush});
        chk("redirect", {31'b0, bus.PC_REDIRECT_o}, {31'b0, e_redir});
        chk("target",   bus.PC_TARGET_o, e_target);
        chk("mtvec",    bus.MTVEC_o,  m_mtvec);
        chk("mepc",     bus.MEPC_o,   m_mepc);
        chk("mcause",   bus.MCAUSE_o, m_mcause);
        chk("mtval",    bus.MTVAL_o,  m_mtval);
        chk("mie",      {31'b0, bus.MIE_o}, {31'b0, m_mie});
        if (bus.PC_REDIRECT_o) begin
            dut_redirects++;
            last_target = bus.PC_TARGET_o;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_inputs();
        bus.ILLEGAL_INSTR_i = 0; bus.ECALL_i = 0; bus.EBREAK_i = 0; bus.MRET_i = 0;
        bus.CSR_WE_i = 0;
`ifdef TRAP_EXT_IRQ_EN
        bus.EXT_IRQ_i = 0;
`endif
    endtask

    task automatic run_until_idle();
        int n;
        n = 0;
        while (m_active && n < 50) begin
            cycle();
            n++;
        end
        chk("settle_busy", {31'b0, bus.BUSY_o}, 32'h0);
    endtask

    initial begin
        int r0, n;
        rstn = 1'b0;
        bus.EN = 1; bus.PIPE_IDLE_i = 1; bus.TRAP_PC_i = '0; bus.TRAP_INSTR_i = '0;
        bus.CSR_ADDR_i = '0; bus.CSR_WDATA_i = '0;
        clear_inputs();
        model_reset();
        cycle();
        cycle();
        // Reset values pinned by hand.
        chk("rst_mtvec",  bus.MTVEC_o, 32'h100);
        chk("rst_mepc",   bus.MEPC_o, 32'h0);
        chk("rst_mcause", bus.MCAUSE_o, 32'h0);
        chk("rst_mtval",  bus.MTVAL_o, 32'h0);
        chk("rst_target", bus.PC_TARGET_o, 32'h0);
        chk("rst_busy",   {31'b0, bus.BUSY_o}, 32'h0);
        chk("rst_flags",  {28'b0, bus.FLUSH_o, bus.PC_REDIRECT_o, bus.MIE_o, bus.STALL_o}, 32'h0);
        rstn = 1'b1;
        cycle();

        // Illegal instruction, pipeline idle: redirect four edges after the request.
        bus.ILLEGAL_INSTR_i = 1; bus.TRAP_PC_i = 32'h40; bus.TRAP_INSTR_i = 32'hFFFF_FFFF;
        cycle();
        clear_inputs();
        chk("ill_flush_e0", {31'b0, bus.FLUSH_o}, 32'h1);
        cycle();
        chk("ill_flush_e1", {31'b0, bus.FLUSH_o}, 32'h0);
        cycle();
        cycle();
        chk("ill_redirect_e3", {31'b0, bus.PC_REDIRECT_o}, 32'h1);
        chk("ill_target",  bus.PC_TARGET_o, 32'h100);
        chk("ill_mcause",  bus.MCAUSE_o, 32'h2);
        chk("ill_mtval",   bus.MTVAL_o, 32'hFFFF_FFFF);
        chk("ill_mepc",    bus.MEPC_o, 32'h40);
        cycle();
        chk("ill_busy_e4", {31'b0, bus.BUSY_o}, 32'h0);

        // MRET round trip.
        bus.CSR_WE_i = 1; bus.CSR_ADDR_i = 12'h300; bus.CSR_WDATA_i = 32'h8;
        cycle();
        clear_inputs();
        chk("rt_mie_set", {31'b0, bus.MIE_o}, 32'h1);
        bus.ECALL_i = 1; bus.TRAP_PC_i = 32'h80; bus.TRAP_INSTR_i = 32'h0000_0073;
        cycle();
        clear_inputs();
        run_until_idle();
        chk("rt_mie_trap", {31'b0, bus.MIE_o}, 32'h0);
        chk("rt_mcause",   bus.MCAUSE_o, 32'd11);
        chk("rt_mepc",     bus.MEPC_o, 32'h80);
        r0 = dut_redirects;
        bus.MRET_i = 1;
        cycle();
        clear_inputs();
        run_until_idle();
        chk("rt_mret_target", last_target, 32'h80);
        chk("rt_mie_back",    {31'b0, bus.MIE_o}, 32'h1);
        chk("rt_redirects",   dut_redirects - r0, 32'h1);

        // Simultaneous ILLEGAL and ECALL.
        r0 = dut_redirects;
        bus.ILLEGAL_INSTR_i = 1; bus.ECALL_i = 1; bus.TRAP_PC_i = 32'h120;
        bus.TRAP_INSTR_i = 32'hDEAD_BEEF;
        cycle();
        clear_inputs();
        run_until_idle();
        chk("sim_mcause",    bus.MCAUSE_o, 32'h2);
        chk("sim_redirects", dut_redirects - r0, 32'h1);

        // Drain timeout: request edge is step 1, redirect shows after step 11.
        bus.PIPE_IDLE_i = 0;
        bus.EBREAK_i = 1; bus.TRAP_PC_i = 32'h204;
        n = 0;
        do begin
            cycle();
            clear_inputs();
            n++;
        end while (!bus.PC_REDIRECT_o && n < 30);
        chk("drain_steps", n, 32'd11);
        chk("drain_mtval", bus.MTVAL_o, 32'h204);
        bus.PIPE_IDLE_i = 1;
        run_until_idle();

        // Reset during DRAIN of an illegal trap.
        bus.PIPE_IDLE_i = 0;
        bus.ILLEGAL_INSTR_i = 1; bus.TRAP_PC_i = 32'h300; bus.TRAP_INSTR_i = 32'h1234_5678;
        cycle();
        clear_inputs();
        cycle();
        cycle();
        rstn = 1'b0;
        model_reset();
        #1;
        chk("mrst_mcause", bus.MCAUSE_o, 32'h0);
        chk("mrst_busy",   {31'b0, bus.BUSY_o}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        r0 = dut_redirects;
        bus.PIPE_IDLE_i = 1;
        for (int i = 0; i < 15; i++) cycle();
        chk("mrst_redirects", dut_redirects - r0, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.EN              = ($urandom_range(0, 7) != 0);
            bus.ILLEGAL_INSTR_i = ($urandom_range(0, 11) == 0);
            bus.EBREAK_i        = ($urandom_range(0, 11) == 0);
            bus.ECALL_i         = ($urandom_range(0, 11) == 0);
            bus.MRET_i          = ($urandom_range(0, 11) == 0);
`ifdef TRAP_EXT_IRQ_EN
            bus.EXT_IRQ_i       = ($urandom_range(0, 5) == 0);
`endif
            bus.PIPE_IDLE_i     = ($urandom_range(0, 2) != 0);
            bus.TRAP_PC_i       = $urandom;
            bus.TRAP_INSTR_i    = $urandom;
            bus.CSR_WE_i        = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 5))
                0: bus.CSR_ADDR_i = 12'h305;
                1: bus.CSR_ADDR_i = 12'h341;
                2: bus.CSR_ADDR_i = 12'h342;
                3: bus.CSR_ADDR_i = 12'h343;
                4: bus.CSR_ADDR_i = 12'h300;
                default: bus.CSR_ADDR_i = 12'($urandom);
            endcase
            bus.CSR_WDATA_i = $urandom;
            cycle();
        end
        clear_inputs();
        bus.EN = 1; bus.PIPE_IDLE_i = 1;
        run_until_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
